// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready producers.
// Optional FWA_BURST_EN: a winner may keep priority for up to MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid_i,
    input  logic [N*W-1:0]   req_data_i,
    output logic [N-1:0]     req_ready_o,
    input  logic             fifo_full_i,
    output logic             fifo_wr_o,
    output logic [W-1:0]     fifo_d_o,
    output logic [2:0]       gnt_id_o,
    output logic             stall_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        STALL = 2'd2
    } state_t;

    if (N < 2 || N > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_param
        $error("fifo_wr_arbiter: parameter out of range");
    end

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  gnt_q, gnt_d;

    logic [7:0]  vld_pad;
    logic [W-1:0] dat [8];
    logic [2:0]  win;
    logic [2:0]  win_nxt;
    logic        any_vld;
    logic        grant;
    logic [3:0]  idx;

    // Pad to 8 lanes so a 3-bit winner index is always in range.
    assign vld_pad = 8'(req_valid_i);

    for (genvar g = 0; g < 8; g++) begin : g_dat
        if (g < N) begin : g_used
            assign dat[g] = req_data_i[g*W +: W];
        end else begin : g_pad
            assign dat[g] = '0;
        end
    end

    // Scan downward so the lane closest to ptr is the last one assigned.
    always_comb begin
        win     = '0;
        any_vld = 1'b0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + 4'(k);
            if (idx >= 4'(N)) begin
                idx = idx - 4'(N);
            end
            if (vld_pad[idx[2:0]]) begin
                win     = idx[2:0];
                any_vld = 1'b1;
            end
        end
    end

    assign grant   = rst & any_vld & ~fifo_full_i;
    assign win_nxt = (win == 3'(N - 1)) ? 3'd0 : win + 3'd1;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < N; i++) begin
            req_ready_o[i] = grant && (win == 3'(i));
        end
    end

    assign fifo_wr_o = grant;
    assign fifo_d_o  = grant ? dat[win] : '0;
    assign gnt_id_o  = gnt_q;
    assign stall_o   = (state_q == STALL);

`ifdef FWA_BURST_EN
    logic [3:0] cnt_q, cnt_d, cnt_eff;

    always_comb begin
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_eff = (win == gnt_q) ? cnt_q : 4'd0;
        if (grant) begin
            gnt_d = win;
            if ({1'b0, cnt_eff} + 5'd1 < 5'(MAX_BURST)) begin
                ptr_d = win;
                cnt_d = cnt_eff + 4'd1;
            end else begin
                ptr_d = win_nxt;
                cnt_d = '0;
            end
        end else if (!any_vld) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        ptr_d = ptr_q;
        gnt_d = gnt_q;
        if (grant) begin
            ptr_d = win_nxt;
            gnt_d = win;
        end
    end
`endif

    // Transitions depend only on this cycle's request/full picture.
    always_comb begin
        state_d = state_q;
        if (!any_vld) begin
            state_d = IDLE;
        end else if (fifo_full_i) begin
            state_d = STALL;
        end else begin
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a
// round-robin reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_wr;
    logic [W-1:0]   fifo_d;
    logic [2:0]     gnt_id;
    logic           stall;

    int n_chk  = 0;
    int n_fail = 0;

    int m_ptr   = 0;
    int m_gnt   = 0;
    int m_cnt   = 0;
    bit m_stall = 1'b0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .fifo_full_i (fifo_full),
        .fifo_wr_o   (fifo_wr),
        .fifo_d_o    (fifo_d),
        .gnt_id_o    (gnt_id),
        .stall_o     (stall)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Check one cycle against the model, then advance the clock and model.
    task automatic cycle();
        int          win;
        int          c;
        bit          found;
        bit          wr;
        logic [N-1:0] rdy;
        logic [W-1:0] d;
        #1;
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (!found && req_valid[i]) begin
                found = 1'b1;
                win   = i;
            end
        end
        wr  = rst && found && !fifo_full;
        rdy = '0;
        if (wr) rdy[win] = 1'b1;
        d = wr ? req_data[win*W +: W] : '0;
        check("fifo_wr", 32'(fifo_wr), 32'(wr));
        check("req_ready", 32'(req_ready), 32'(rdy));
        check("fifo_d", 32'(fifo_d), 32'(d));
        check("gnt_id", 32'(gnt_id), 32'(m_gnt));
        check("stall", 32'(stall), 32'(m_stall));
        @(posedge clk);
        if (!rst) begin
            m_ptr   = 0;
            m_gnt   = 0;
            m_cnt   = 0;
            m_stall = 1'b0;
        end else begin
            m_stall = found && fifo_full;
            if (wr) begin
`ifdef FWA_BURST_EN
                c = (win == m_gnt) ? m_cnt : 0;
                if (c + 1 < MB) begin
                    m_ptr = win;
                    m_cnt = c + 1;
                end else begin
                    m_ptr = (win + 1) % N;
                    m_cnt = 0;
                end
`else
                c     = 0;
                m_ptr = (win + 1) % N;
`endif
                m_gnt = win;
            end else if (!found) begin
                m_cnt = 0;
            end
        end
        #1;
    endtask

    task automatic set_data_a0();
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = 8'(8'hA0 + i);
        end
    endtask

    initial begin
        logic [7:0] exp_d;
        rst       = 1'b0;
        req_valid = '1;
        fifo_full = 1'b0;
        set_data_a0();
        @(posedge clk);
        #1;

        // reset held with all requesters valid
        repeat (2) cycle();
        rst = 1'b1;

        // rotation, one beat each
        for (int k = 0; k < 8; k++) begin
            #1;
`ifdef FWA_BURST_EN
            exp_d = 8'(8'hA0 + (k / MB) % N);
`else
            exp_d = 8'(8'hA0 + k % N);
`endif
            check("rot_seq", 32'(fifo_d), 32'(exp_d));
            cycle();
        end

        // full backpressure on requester 2
        req_valid = 4'b0100;
        fifo_full = 1'b1;
        repeat (3) cycle();
        fifo_full = 1'b0;
        repeat (2) cycle();

        // sparse requesters 1 and 3 with wrap
        req_valid = '1;
        repeat (2) cycle();
        req_valid = 4'b1010;
        repeat (6) cycle();

        // two persistent requesters
        req_valid = 4'b0011;
        for (int k = 0; k < 16; k++) begin
            cycle();
        end

        // reset during an accepted beat
        req_valid = '1;
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        repeat (3) cycle();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            req_valid = N'($urandom);
            req_data  = (N*W)'($urandom);
            fifo_full = ($urandom_range(0, 9) < 3);
            rst       = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
